// File: rtl/tdc_pkg.sv
// Shared constants and helpers for the ADPLL TDC word decoder.
//
// Contents:
//   CNT_W / PH_W / FRAC_W / WORD_W  - datapath widths
//   capture_t                       - stage-1 capture record (count + phase snapshot)
//   johnson_decode()                - popcount-based Johnson phase decode
package tdc_pkg;

  localparam int CNT_W  = 7;              // DCO ripple counter width (mod 128)
  localparam int PH_W   = 16;             // ring taps in the phase snapshot
  localparam int FRAC_W = 5;              // log2(2*PH_W) fractional bits
  localparam int WORD_W = CNT_W + FRAC_W; // output phase word width

  // Number of distinct Johnson states in the ring (2*PH_W), sized one bit
  // wider than frac so that the subtraction below cannot overflow.
  localparam logic [FRAC_W:0] JOHNSON_STATES = (FRAC_W+1)'(2 * PH_W);

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [PH_W-1:0]  phase;
  } capture_t;

  // Johnson decode by popcount.
  //   MSB clear: the ring is filling with ones  -> frac = popcount
  //   MSB set  : the ring is draining ones      -> frac = 2*PH_W - popcount
  // Using popcount rather than locating a single 0/1 edge means a bubble
  // (one flipped tap) moves the result by at most one LSB.
  function automatic logic [FRAC_W-1:0] johnson_decode(input logic [PH_W-1:0] ph);
    logic [FRAC_W:0] pc;
    logic [FRAC_W:0] full;
    pc = '0;
    for (int i = 0; i < PH_W; i++) begin
      pc = pc + {{FRAC_W{1'b0}}, ph[i]};
    end
    if (ph[PH_W-1]) begin
      full = JOHNSON_STATES - pc;
    end else begin
      full = pc;
    end
    return full[FRAC_W-1:0];
  endfunction

endpackage

// File: rtl/tdc_phase_decoder.sv
// Combinational Johnson phase decoder.
//
// Ports:
//   phase  in  PH_W    stage-1 registered ring tap snapshot
//   frac   out FRAC_W  fractional DCO phase, LSB = T_dco/(2*PH_W)
module tdc_phase_decoder
  import tdc_pkg::*;
(
  input  logic [PH_W-1:0]   phase,
  output logic [FRAC_W-1:0] frac
);

  always_comb begin
    frac = johnson_decode(phase);
  end

endmodule

// File: rtl/tdc_word_decoder.sv
// Digital back-end of the ADPLL time-to-digital converter.
//
// Captures the DCO ripple counter and the ring phase snapshot on every
// enabled reference edge, decodes the snapshot to a fractional phase and
// produces the DCO phase word {counter, frac} plus the per-cycle increment.
//
// Ports:
//   clk         in   1       reference clock, rising edge
//   rst         in   1       asynchronous reset, active low
//   en          in   1       capture enable
//   counter_in  in   CNT_W   DCO cycle count from the analog front-end
//   phase_in    in   PH_W    Johnson-coded ring tap snapshot
//   tdc_word    out  WORD_W  DCO phase, LSB = T_dco/32, wraps mod 2^WORD_W
//   tdc_diff    out  WORD_W  tdc_word minus previous tdc_word, mod 2^WORD_W
//   valid       out  1       tdc_diff spans two consecutive enabled samples
//
// Handshake: valid is a qualifier only (no ready). When valid is high,
// tdc_diff holds a genuine frequency measurement for the current tdc_word;
// when low, tdc_diff is either 0 (first word after a gap) or held stale.
module tdc_word_decoder
  import tdc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CNT_W-1:0]  counter_in,
  input  logic [PH_W-1:0]   phase_in,
  output logic [WORD_W-1:0] tdc_word,
  output logic [WORD_W-1:0] tdc_diff,
  output logic              valid
);

  // ---------------------------------------------------------------------
  // Stage 1: input capture flops. The front-end samples on clk, so these
  // are plain registers with no synchronizer.
  // ---------------------------------------------------------------------
  capture_t s1;
  logic     en_s1;   // en delayed to line up with the s1 data

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1    <= '0;
      en_s1 <= 1'b0;
    end else begin
      en_s1 <= en;
      if (en) begin
        s1.cnt   <= counter_in;
        s1.phase <= phase_in;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Phase decode between the stages
  // ---------------------------------------------------------------------
  logic [FRAC_W-1:0] frac;

  tdc_phase_decoder u_phase_decoder (
    .phase (s1.phase),
    .frac  (frac)
  );

  logic [WORD_W-1:0] word_next;
  logic [WORD_W-1:0] diff_next;

  always_comb begin
    word_next = {s1.cnt, frac};
    // Unsigned modular subtraction absorbs the counter wrap 127 -> 0.
    diff_next = word_next - tdc_word;
  end

  // ---------------------------------------------------------------------
  // Stage 2: output word, difference and validity.
  // have_prev marks that tdc_word holds a sample from the immediately
  // preceding enabled cycle; it is cleared by any gap in en_s1 so the
  // first word after a gap cannot produce a bogus difference.
  // ---------------------------------------------------------------------
  logic have_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tdc_word  <= '0;
      tdc_diff  <= '0;
      valid     <= 1'b0;
      have_prev <= 1'b0;
    end else if (en_s1) begin
      tdc_word  <= word_next;
      tdc_diff  <= have_prev ? diff_next : '0;
      valid     <= have_prev;
      have_prev <= 1'b1;
    end else begin
      valid     <= 1'b0;
      have_prev <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdc_word_decoder.sv
// Directed self-checking bench for tdc_word_decoder.
module tb_tdc_word_decoder;

  localparam int CNT_W  = 7;
  localparam int PH_W   = 16;
  localparam int WORD_W = 12;

  logic              clk;
  logic              rst;
  logic              en;
  logic [CNT_W-1:0]  counter_in;
  logic [PH_W-1:0]   phase_in;
  logic [WORD_W-1:0] tdc_word;
  logic [WORD_W-1:0] tdc_diff;
  logic              valid;

  int n_checks;
  int n_fail;

  tdc_word_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .counter_in (counter_in),
    .phase_in   (phase_in),
    .tdc_word   (tdc_word),
    .tdc_diff   (tdc_diff),
    .valid      (valid)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [CNT_W-1:0] c, input logic [PH_W-1:0] p);
    counter_in = c;
    phase_in   = p;
  endtask

  // Johnson state k (0..31) built from its shape, independent of popcount
  function automatic logic [PH_W-1:0] johnson(input int k);
    logic [31:0] ones;
    logic [31:0] v;
    ones = 32'h0000_FFFF;
    if (k <= 16) v = (32'h1 << k) - 32'h1;
    else         v = (ones << (k - 16)) & ones;
    return v[PH_W-1:0];
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    en  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(CNT_W'($urandom_range(0, 127)), PH_W'($urandom_range(0, 65535)));
      step();
      n_checks++;
      if (tdc_word !== 12'd0 || tdc_diff !== 12'd0 || valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: word=%0d diff=%0d valid=%0b expected 0/0/0",
                 tdc_word, tdc_diff, valid);
      end
    end
    drive(7'd3, 16'h0001);   // word 3*32+1 = 97
    rst = 1'b1;
    step();
    n_checks++;
    if (tdc_word !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_latency1: word=%0d expected 0", tdc_word);
    end
    step();
    n_checks++;
    if (tdc_word !== 12'd97 || tdc_diff !== 12'd0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_word: word=%0d diff=%0d valid=%0b expected 97/0/0",
               tdc_word, tdc_diff, valid);
    end
  endtask

  task automatic test_decode_sweep();
    logic [WORD_W-1:0] exp_w;
    for (int i = 0; i <= 32; i++) begin
      if (i < 32) drive(7'd5, johnson(i));
      step();
      if (i >= 1) begin
        exp_w = WORD_W'(160 + i - 1);
        n_checks++;
        if (tdc_word !== exp_w) begin
          n_fail++;
          $display("FAIL sweep_word k=%0d: word=%0d expected %0d", i - 1, tdc_word, exp_w);
        end
        if (i >= 2) begin
          n_checks++;
          if (tdc_diff !== 12'd1 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_diff k=%0d: diff=%0d valid=%0b expected 1/1",
                     i - 1, tdc_diff, valid);
          end
        end
      end
    end
  endtask

  task automatic test_bubble();
    drive(7'd5, 16'h0005);
    step();
    step();
    n_checks++;
    if (tdc_word !== 12'd162) begin
      n_fail++;
      $display("FAIL bubble: word=%0d expected 162", tdc_word);
    end
  endtask

  task automatic test_wrap();
    drive(7'd127, 16'hFFFE);
    step();
    drive(7'd2, 16'h0003);
    step();
    n_checks++;
    if (tdc_word !== 12'd4081) begin
      n_fail++;
      $display("FAIL wrap_word0: word=%0d expected 4081", tdc_word);
    end
    step();
    n_checks++;
    if (tdc_word !== 12'd66 || tdc_diff !== 12'd81 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_word1: word=%0d diff=%0d valid=%0b expected 66/81/1",
               tdc_word, tdc_diff, valid);
    end
  endtask

  task automatic test_steady_freq();
    logic [WORD_W-1:0] exp_q[$];
    logic [WORD_W-1:0] exp_w;
    int c;
    int f;
    c = 10;
    f = 3;
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) begin
        drive(CNT_W'(c), johnson(f));
        exp_q.push_back(WORD_W'(c * 32 + f));
        f = f + 2;
        c = c + 13 + f / 32;
        f = f % 32;
        c = c % 128;
      end
      step();
      if (i >= 1) begin
        exp_w = exp_q.pop_front();
        n_checks++;
        if (tdc_word !== exp_w) begin
          n_fail++;
          $display("FAIL steady_word i=%0d: word=%0d expected %0d", i - 1, tdc_word, exp_w);
        end
        if (i >= 2) begin
          n_checks++;
          if (tdc_diff !== 12'd418 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL steady_diff i=%0d: diff=%0d valid=%0b expected 418/1",
                     i - 1, tdc_diff, valid);
          end
        end
      end
    end
  endtask

  task automatic test_enable_gating();
    drive(7'd20, 16'h0003);   // 642
    step();
    step();
    step();
    en = 1'b0;
    drive(7'd50, 16'h00FF);
    step();
    n_checks++;
    if (tdc_word !== 12'd642 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL gate_edge1: word=%0d valid=%0b expected 642/1", tdc_word, valid);
    end
    drive(7'd51, 16'h0FFF);
    step();
    n_checks++;
    if (tdc_word !== 12'd642 || tdc_diff !== 12'd0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL gate_hold1: word=%0d diff=%0d valid=%0b expected 642/0/0",
               tdc_word, tdc_diff, valid);
    end
    drive(7'd52, 16'hF000);
    step();
    n_checks++;
    if (tdc_word !== 12'd642 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL gate_hold2: word=%0d valid=%0b expected 642/0", tdc_word, valid);
    end
    en = 1'b1;
    drive(7'd21, 16'h0007);   // 675
    step();
    drive(7'd22, 16'h000F);   // 708
    step();
    n_checks++;
    if (tdc_word !== 12'd675 || tdc_diff !== 12'd0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL regate_first: word=%0d diff=%0d valid=%0b expected 675/0/0",
               tdc_word, tdc_diff, valid);
    end
    step();
    n_checks++;
    if (tdc_word !== 12'd708 || tdc_diff !== 12'd33 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL regate_second: word=%0d diff=%0d valid=%0b expected 708/33/1",
               tdc_word, tdc_diff, valid);
    end
  endtask

  task automatic test_mid_reset();
    drive(7'd40, 16'h00FF);   // 40*32+8 = 1288
    step();
    step();
    #2 rst = 1'b0;            // mid-cycle, away from any edge
    #1;
    n_checks++;
    if (tdc_word !== 12'd0 || tdc_diff !== 12'd0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_clear: word=%0d diff=%0d valid=%0b expected 0/0/0",
               tdc_word, tdc_diff, valid);
    end
    step();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if (tdc_word !== 12'd1288 || tdc_diff !== 12'd0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_restart: word=%0d diff=%0d valid=%0b expected 1288/0/0",
               tdc_word, tdc_diff, valid);
    end
    step();
    n_checks++;
    if (valid !== 1'b1 || tdc_diff !== 12'd0) begin
      n_fail++;
      $display("FAIL midreset_valid: diff=%0d valid=%0b expected 0/1", tdc_diff, valid);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b0;
    en         = 1'b0;
    counter_in = '0;
    phase_in   = '0;
    #1;
    test_reset();
    test_decode_sweep();
    test_bubble();
    test_wrap();
    test_steady_freq();
    test_enable_gating();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
